// File: rtl/alu_collector_pkg.sv
// ============================================================================
// Package : alu_collector_pkg
// Types, opcode constants and need-mask decode for the ALU operand collector.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

package alu_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ISSUE   = 2'd2
    } coll_state_e;

    localparam logic [1:0] NEED_NONE = 2'b00;
    localparam logic [1:0] NEED_A    = 2'b01;
    localparam logic [1:0] NEED_B    = 2'b10;
    localparam logic [1:0] NEED_AB   = 2'b11;

    // Arithmetic mode (mode=1) opcodes
    localparam int unsigned ARITH_ADD     = 0;
    localparam int unsigned ARITH_SUB     = 1;
    localparam int unsigned ARITH_ADD_CIN = 2;
    localparam int unsigned ARITH_SUB_CIN = 3;
    localparam int unsigned ARITH_INC_A   = 4;
    localparam int unsigned ARITH_DEC_A   = 5;
    localparam int unsigned ARITH_INC_B   = 6;
    localparam int unsigned ARITH_DEC_B   = 7;
    localparam int unsigned ARITH_CMP     = 8;
    localparam int unsigned ARITH_MUL_INC = 9;
    localparam int unsigned ARITH_MUL_SHL = 10;

    // Logic mode (mode=0) opcodes
    localparam int unsigned LOGIC_AND    = 0;
    localparam int unsigned LOGIC_NAND   = 1;
    localparam int unsigned LOGIC_OR     = 2;
    localparam int unsigned LOGIC_NOR    = 3;
    localparam int unsigned LOGIC_XOR    = 4;
    localparam int unsigned LOGIC_XNOR   = 5;
    localparam int unsigned LOGIC_NOT_A  = 6;
    localparam int unsigned LOGIC_NOT_B  = 7;
    localparam int unsigned LOGIC_SHR1_A = 8;
    localparam int unsigned LOGIC_SHL1_A = 9;
    localparam int unsigned LOGIC_SHR1_B = 10;
    localparam int unsigned LOGIC_SHL1_B = 11;
    localparam int unsigned LOGIC_ROL    = 12;
    localparam int unsigned LOGIC_ROR    = 13;

    // Unknown opcodes need nothing, so they issue with whatever arrived.
    function automatic logic [1:0] need_mask(input logic mode, input logic [31:0] cmd);
        logic [1:0] need;
        need = NEED_NONE;
        if (mode) begin
            case (cmd)
                ARITH_INC_A, ARITH_DEC_A:                         need = NEED_A;
                ARITH_INC_B, ARITH_DEC_B:                         need = NEED_B;
                ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN, ARITH_SUB_CIN,
                ARITH_CMP, ARITH_MUL_INC, ARITH_MUL_SHL:          need = NEED_AB;
                default:                                          need = NEED_NONE;
            endcase
        end else begin
            case (cmd)
                LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A:          need = NEED_A;
                LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B:          need = NEED_B;
                LOGIC_AND, LOGIC_NAND, LOGIC_OR, LOGIC_NOR,
                LOGIC_XOR, LOGIC_XNOR, LOGIC_ROL, LOGIC_ROR:      need = NEED_AB;
                default:                                          need = NEED_NONE;
            endcase
        end
        return need;
    endfunction

endpackage : alu_collector_pkg

`default_nettype wire

// File: rtl/alu_collect_timer.sv
// ============================================================================
// Module  : alu_collect_timer
// Counts enabled cycles since clear; flags the cycle that reaches TIMEOUT.
// Used only when ALU_COLLECT_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_collect_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;

    // Asserted during the TIMEOUT-th enabled cycle, so the drop lands on its edge.
    assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule : alu_collect_timer

`default_nettype wire

// File: rtl/alu_operand_collector.sv
// ============================================================================
// Module  : alu_operand_collector
// Gathers split A/B operand beats per command and issues one registered
// valid/ready request to the ALU. Optional drop-on-timeout: ALU_COLLECT_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_operand_collector
    import alu_collector_pkg::*;
#(
    parameter int DW      = `DATA_WIDTH,
    parameter int CW      = `CMD_WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [1:0]    in_valid,
    input  logic [DW-1:0] in_opa,
    input  logic [DW-1:0] in_opb,
    input  logic [CW-1:0] in_cmd,
    input  logic          in_mode,
    input  logic          in_cin,
    output logic          in_ready,
    output logic [DW-1:0] alu_opa,
    output logic [DW-1:0] alu_opb,
    output logic [CW-1:0] alu_cmd,
    output logic          alu_mode,
    output logic          alu_cin,
    output logic [1:0]    alu_inp_valid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err_timeout
);

    coll_state_e   state_q;
    logic [1:0]    got_q;
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [CW-1:0] cmd_q;
    logic          mode_q;
    logic          cin_q;
    logic          out_valid_q;
    logic          err_q;

    logic          accept;
    logic          mode_d;
    logic [CW-1:0] cmd_d;
    logic [1:0]    got_d;
    logic [1:0]    need_d;
    logic          done_d;
    logic          expired;

    assign in_ready = rst && ce && (state_q != ST_ISSUE);
    assign accept   = in_ready && (in_valid != 2'b00);

    // The first beat defines the command; later beats only contribute operands.
    assign mode_d = (state_q == ST_IDLE) ? in_mode : mode_q;
    assign cmd_d  = (state_q == ST_IDLE) ? in_cmd  : cmd_q;
    assign got_d  = (state_q == ST_IDLE) ? in_valid : (got_q | in_valid);
    assign need_d = need_mask(mode_d, 32'(cmd_d));
    assign done_d = ((got_d & need_d) == need_d);

`ifdef ALU_COLLECT_TIMEOUT_EN
    alu_collect_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (ce && (state_q != ST_COLLECT)),
        .enable_i  (ce && (state_q == ST_COLLECT)),
        .expired_o (expired)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        err_q <= 1'b0;
        if (!rst) begin
            state_q     <= ST_IDLE;
            got_q       <= 2'b00;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q  <= in_cmd;
                        mode_q <= in_mode;
                        cin_q  <= in_cin;
                        if (in_valid[0]) opa_q <= in_opa;
                        if (in_valid[1]) opb_q <= in_opb;
                        got_q  <= got_d;
                        if (done_d) begin
                            state_q     <= ST_ISSUE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        if (in_valid[0]) opa_q <= in_opa;
                        if (in_valid[1]) opb_q <= in_opb;
                        got_q <= got_d;
                    end
                    // A completing beat on the expiry cycle takes priority.
                    if (accept && done_d) begin
                        state_q     <= ST_ISSUE;
                        out_valid_q <= 1'b1;
                    end else if (expired) begin
                        state_q <= ST_IDLE;
                        got_q   <= 2'b00;
                        err_q   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        got_q       <= 2'b00;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    got_q       <= 2'b00;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_opa       = got_q[0] ? opa_q : '0;
    assign alu_opb       = got_q[1] ? opb_q : '0;
    assign alu_cmd       = cmd_q;
    assign alu_mode      = mode_q;
    assign alu_cin       = cin_q;
    assign alu_inp_valid = got_q;
    assign out_valid     = out_valid_q;
    assign err_timeout   = err_q;

endmodule : alu_operand_collector

`default_nettype wire

// File: tb/tb_alu_operand_collector.sv
// ============================================================================
// Module  : tb_alu_operand_collector
// Self-checking bench: vector table, directed corner sequences, random traffic
// against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_collector;

    localparam int TMO = 16;
`ifdef ALU_COLLECT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       ce;
    logic [1:0] in_valid;
    logic [7:0] in_opa, in_opb;
    logic [3:0] in_cmd;
    logic       in_mode, in_cin;
    logic       in_ready;
    logic [7:0] alu_opa, alu_opb;
    logic [3:0] alu_cmd;
    logic       alu_mode, alu_cin;
    logic [1:0] alu_inp_valid;
    logic       out_valid;
    logic       out_ready;
    logic       err_timeout;

    alu_operand_collector #(.DW(8), .CW(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .in_valid(in_valid), .in_opa(in_opa), .in_opb(in_opb),
        .in_cmd(in_cmd), .in_mode(in_mode), .in_cin(in_cin),
        .in_ready(in_ready),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
        .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
        .out_valid(out_valid), .out_ready(out_ready), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one command in flight ----------------
    logic [1:0] need_tab [2][16];
    int   m_phase;              // 0 waiting for a command, 1 gathering, 2 offered to ALU
    logic [1:0] m_got;
    logic [7:0] m_a, m_b;
    logic [3:0] m_cmd;
    logic m_mode, m_cin, m_err;
    int   m_age;

    task automatic build_need();
        int m1_ab[7] = '{0, 1, 2, 3, 8, 9, 10};
        int m1_a[2]  = '{4, 5};
        int m1_b[2]  = '{6, 7};
        int m0_ab[8] = '{0, 1, 2, 3, 4, 5, 12, 13};
        int m0_a[3]  = '{6, 8, 9};
        int m0_b[3]  = '{7, 10, 11};
        for (int i = 0; i < 16; i++) begin
            need_tab[0][i] = 2'b00;
            need_tab[1][i] = 2'b00;
        end
        foreach (m1_ab[i]) need_tab[1][m1_ab[i]] = 2'b11;
        foreach (m1_a[i])  need_tab[1][m1_a[i]]  = 2'b01;
        foreach (m1_b[i])  need_tab[1][m1_b[i]]  = 2'b10;
        foreach (m0_ab[i]) need_tab[0][m0_ab[i]] = 2'b11;
        foreach (m0_a[i])  need_tab[0][m0_a[i]]  = 2'b01;
        foreach (m0_b[i])  need_tab[0][m0_b[i]]  = 2'b10;
    endtask

    task automatic model_edge(input logic r, input logic c, input logic [1:0] v,
                              input logic [7:0] a, input logic [7:0] b, input logic md,
                              input logic [3:0] cm, input logic ci, input logic ordy);
        bit fresh, fired;
        logic [1:0] nd;
        fired = 1'b0;
        if (!r) begin
            m_phase = 0; m_got = 0; m_a = 0; m_b = 0;
            m_cmd = 0; m_mode = 0; m_cin = 0; m_age = 0;
        end else if (c) begin
            if (m_phase == 2) begin
                if (ordy) begin m_phase = 0; m_got = 0; end
            end else begin
                fresh = (m_phase == 0);
                if (v != 2'b00) begin
                    if (fresh) begin
                        m_cmd = cm; m_mode = md; m_cin = ci; m_got = 0; m_age = 0;
                    end
                    if (v[0]) m_a = a;
                    if (v[1]) m_b = b;
                    m_got = m_got | v;
                end
                nd = need_tab[m_mode][m_cmd];
                if (v != 2'b00 && (m_got & nd) == nd) begin
                    m_phase = 2;
                end else if (v != 2'b00 && fresh) begin
                    m_phase = 1;
                end else if (!fresh) begin
                    m_age++;
                    if (TO_EN && m_age >= TMO) begin
                        m_phase = 0; m_got = 0; fired = 1'b1;
                    end
                end
            end
        end
        m_err = fired;
    endtask

    // One clock cycle: drive, check ready, clock the model, compare outputs.
    task automatic cyc(input logic r, input logic c, input logic [1:0] v,
                       input logic [7:0] a, input logic [7:0] b, input logic md,
                       input logic [3:0] cm, input logic ci, input logic ordy);
        rst = r; ce = c; in_valid = v; in_opa = a; in_opb = b;
        in_mode = md; in_cmd = cm; in_cin = ci; out_ready = ordy;
        #1;
        chk("m_in_ready", in_ready, r && c && (m_phase != 2));
        @(posedge clk);
        model_edge(r, c, v, a, b, md, cm, ci, ordy);
        #1;
        chk("m_out_valid", out_valid, m_phase == 2);
        chk("m_inp_valid", alu_inp_valid, m_got);
        chk("m_opa", alu_opa, m_got[0] ? m_a : 8'h00);
        chk("m_opb", alu_opb, m_got[1] ? m_b : 8'h00);
        chk("m_cmd", alu_cmd, m_cmd);
        chk("m_mode", alu_mode, m_mode);
        chk("m_cin", alu_cin, m_cin);
        chk("m_err", err_timeout, m_err);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 4'h0, 1'b0, ordy);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       mode;
        logic [3:0] cmd;
        logic       cin;
        logic [1:0] v;
        logic [7:0] a;
        logic [7:0] b;
        logic       ov;
        logic [1:0] iv;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t tab[10];

    initial begin
        rst = 0; ce = 1; in_valid = 0; in_opa = 0; in_opb = 0;
        in_cmd = 0; in_mode = 0; in_cin = 0; out_ready = 0;
        build_need();
        m_phase = 0; m_got = 0; m_a = 0; m_b = 0; m_cmd = 0;
        m_mode = 0; m_cin = 0; m_age = 0; m_err = 0;

        tab[0] = '{1'b1, 4'd0,  1'b1, 2'b11, 8'h12, 8'h34, 1'b1, 2'b11, 8'h12, 8'h34};
        tab[1] = '{1'b1, 4'd4,  1'b0, 2'b01, 8'hFF, 8'hAA, 1'b1, 2'b01, 8'hFF, 8'h00};
        tab[2] = '{1'b1, 4'd6,  1'b1, 2'b10, 8'h11, 8'h5A, 1'b1, 2'b10, 8'h00, 8'h5A};
        tab[3] = '{1'b0, 4'd8,  1'b0, 2'b01, 8'hC1, 8'h22, 1'b1, 2'b01, 8'hC1, 8'h00};
        tab[4] = '{1'b0, 4'd11, 1'b1, 2'b10, 8'h33, 8'h9E, 1'b1, 2'b10, 8'h00, 8'h9E};
        tab[5] = '{1'b0, 4'd13, 1'b0, 2'b01, 8'h44, 8'h55, 1'b0, 2'b01, 8'h44, 8'h00};
        tab[6] = '{1'b1, 4'd15, 1'b1, 2'b01, 8'h66, 8'h77, 1'b1, 2'b01, 8'h66, 8'h00};
        tab[7] = '{1'b0, 4'd14, 1'b0, 2'b10, 8'h88, 8'h99, 1'b1, 2'b10, 8'h00, 8'h99};
        tab[8] = '{1'b1, 4'd7,  1'b0, 2'b01, 8'hAB, 8'hCD, 1'b0, 2'b01, 8'hAB, 8'h00};
        tab[9] = '{1'b0, 4'd6,  1'b1, 2'b11, 8'h0F, 8'hF0, 1'b1, 2'b11, 8'h0F, 8'hF0};

        // Reset state
        do_reset();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_inp_valid", alu_inp_valid, 0);
        chk("rst_opa", alu_opa, 0);
        chk("rst_cmd", alu_cmd, 0);

        // Single-beat vector table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            cyc(1'b1, 1'b1, tab[i].v, tab[i].a, tab[i].b, tab[i].mode, tab[i].cmd, tab[i].cin, 1'b0);
            chk("tab_out_valid", out_valid, tab[i].ov);
            chk("tab_inp_valid", alu_inp_valid, tab[i].iv);
            chk("tab_opa", alu_opa, tab[i].ea);
            chk("tab_opb", alu_opb, tab[i].eb);
            chk("tab_cmd", alu_cmd, tab[i].cmd);
            chk("tab_cin", alu_cin, tab[i].cin);
            idle(1'b1);
            chk("tab_drain", out_valid, 0);
        end

        // Split beats: A in cycle 0, B in cycle 3 with a different cmd
        do_reset();
        cyc(1'b1, 1'b1, 2'b01, 8'h05, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("split_wait", out_valid, 0);
        cyc(1'b1, 1'b1, 2'b10, 8'h00, 8'h07, 1'b0, 4'd9, 1'b1, 1'b0);
        chk("split_ov", out_valid, 1);
        chk("split_opa", alu_opa, 8'h05);
        chk("split_opb", alu_opb, 8'h07);
        chk("split_cmd", alu_cmd, 4'd0);
        chk("split_mode", alu_mode, 1);

        // Timeout: lone A in cycle 0, nothing else
        do_reset();
        cyc(1'b1, 1'b1, 2'b01, 8'h55, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            idle(1'b0);
            chk("to_err", err_timeout, TO_EN && (c + 1 == 17));
            chk("to_ov", out_valid, 0);
            chk("to_ready", in_ready, 1);
        end

        // Boundary: B arrives in the last allowed cycle
        do_reset();
        cyc(1'b1, 1'b1, 2'b01, 8'h5C, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 15; c++) idle(1'b0);
        cyc(1'b1, 1'b1, 2'b10, 8'h00, 8'hC5, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("bnd_ov", out_valid, 1);
        chk("bnd_err", err_timeout, 0);
        chk("bnd_opb", alu_opb, 8'hC5);

        // Backpressure in ISSUE with competing beats offered
        do_reset();
        cyc(1'b1, 1'b1, 2'b11, 8'h21, 8'h43, 1'b1, 4'd1, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b1, 2'b11, 8'h99, 8'h88, 1'b0, 4'd2, 1'b1, 1'b0);
            chk("bp_ov", out_valid, 1);
            chk("bp_opa", alu_opa, 8'h21);
            chk("bp_opb", alu_opb, 8'h43);
            chk("bp_cmd", alu_cmd, 4'd1);
            chk("bp_ready", in_ready, 0);
        end
        idle(1'b1);
        chk("bp_release", out_valid, 0);

        // Clock-enable freeze while collecting
        do_reset();
        cyc(1'b1, 1'b1, 2'b01, 8'h3A, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) idle(1'b0);
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, 1'b0, 2'b10, 8'h00, 8'h77, 1'b1, 4'd0, 1'b0, 1'b1);
            chk("ce_ready", in_ready, 0);
            chk("ce_ov", out_valid, 0);
            chk("ce_err", err_timeout, 0);
        end
        for (int k = 1; k <= 14; k++) begin
            idle(1'b0);
            chk("ce_resume_err", err_timeout, TO_EN && (k == 11));
        end

        // Reset in the middle of ISSUE, then a fresh command
        do_reset();
        cyc(1'b1, 1'b1, 2'b11, 8'hDE, 8'hAD, 1'b1, 4'd3, 1'b1, 1'b0);
        chk("rmid_ov", out_valid, 1);
        do_reset();
        chk("rmid_ov0", out_valid, 0);
        chk("rmid_opa0", alu_opa, 0);
        chk("rmid_cin0", alu_cin, 0);
        cyc(1'b1, 1'b1, 2'b11, 8'h3C, 8'hC3, 1'b0, 4'd4, 1'b0, 1'b0);
        chk("rmid_new_ov", out_valid, 1);
        chk("rmid_new_opa", alu_opa, 8'h3C);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic r, c, o;
            logic [1:0] v;
            r = ($urandom_range(0, 59) != 0);
            c = ($urandom_range(0, 7) != 0);
            o = $urandom_range(0, 1) != 0;
            v = ($urandom_range(0, 9) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
            if ((n / 80) % 2 == 1 && $urandom_range(0, 3) != 0) v = 2'b00;
            cyc(r, c, v, 8'($urandom), 8'($urandom), 1'($urandom),
                4'($urandom), 1'($urandom), o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_operand_collector

`default_nettype wire
